// File: rtl/burst_packer.sv
// burst_packer: collects BEATS consecutive input beats into one wide word.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   beat present (held high across a burst)
//   in_data    beat payload, DATABIT bits
//   in_ready   high only while idle: a whole burst can be accepted
//   out_valid  packed word available
//   out_ready  consumer accepts the packed word
//   out_data   packed burst, beat 0 in the LSBs
//   out_err    one-cycle pulse on a short burst or an overrun
//   out_sum    (only with BURST_PACKER_CHKSUM_EN) sum of all beats mod 2^DATABIT
//
// Optional feature macro: BURST_PACKER_CHKSUM_EN

module burst_packer #(
    parameter int unsigned DATABIT = 32,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned CNT_BIT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATABIT-1:0]         in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATABIT*BEATS-1:0]   out_data,
    output logic                       out_err
`ifdef BURST_PACKER_CHKSUM_EN
    ,
    output logic [DATABIT-1:0]         out_sum
`endif
);

    localparam int unsigned OUTBIT = DATABIT * BEATS;
    localparam logic [CNT_BIT-1:0] LAST_SLOT = CNT_BIT'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_BIT-1:0]   count;
    logic [DATABIT-1:0]   slots [BEATS];
    logic [OUTBIT-1:0]    packed_c;

    // Word as it will look once the beat on in_data fills the last slot.
    always_comb begin
        packed_c = '0;
        for (int i = 0; i < int'(BEATS) - 1; i++) begin
            packed_c[i*DATABIT +: DATABIT] = slots[i];
        end
        packed_c[(BEATS-1)*DATABIT +: DATABIT] = in_data;
    end

`ifdef BURST_PACKER_CHKSUM_EN
    logic [DATABIT-1:0] sum_c;

    // Checksum of the completing burst, wrapping at DATABIT bits.
    always_comb begin
        sum_c = in_data;
        for (int i = 0; i < int'(BEATS) - 1; i++) begin
            sum_c = sum_c + slots[i];
        end
    end

    // Checksum register loads alongside out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_sum <= '0;
        end else if (state == COLLECT && in_valid && count == LAST_SLOT) begin
            out_sum <= sum_c;
        end
    end
`else
    // Checksum feature not built: no adder, no out_sum port.
`endif

    // Burst FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            for (int i = 0; i < int'(BEATS); i++) begin
                slots[i] <= '0;
            end
        end else begin
            out_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        slots[0] <= in_data;
                        count    <= CNT_BIT'(1);
                        in_ready <= 1'b0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        slots[count] <= in_data;
                        if (count == LAST_SLOT) begin
                            count     <= '0;
                            out_data  <= packed_c;
                            out_valid <= 1'b1;
                            state     <= FULL;
                        end else begin
                            count <= count + CNT_BIT'(1);
                        end
                    end else begin
                        // Burst ended early: drop the partial beats.
                        count    <= '0;
                        out_err  <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                FULL: begin
                    // Any beat arriving here is dropped, including the handshake cycle.
                    if (in_valid) begin
                        out_err <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    count    <= '0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_packer.sv
// Self-checking bench for burst_packer: directed scenarios plus random traffic
// against a queue-based reference model.

module tb_burst_packer;

    localparam int unsigned DATABIT = 32;
    localparam int unsigned BEATS   = 4;
    localparam int unsigned CNT_BIT = 2;
    localparam int unsigned OUTBIT  = DATABIT * BEATS;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [DATABIT-1:0]   in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUTBIT-1:0]    out_data;
    logic                 out_err;
`ifdef BURST_PACKER_CHKSUM_EN
    logic [DATABIT-1:0]   out_sum;
`endif

    burst_packer #(
        .DATABIT (DATABIT),
        .BEATS   (BEATS),
        .CNT_BIT (CNT_BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef BURST_PACKER_CHKSUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: beats of the burst in progress, plus the held word.
    logic [DATABIT-1:0] m_q [$];
    bit                 m_hold;
    logic [OUTBIT-1:0]  m_word;
    logic [DATABIT-1:0] m_sum;
    bit                 m_err;

    function automatic void model_reset();
        m_q.delete();
        m_hold = 0;
        m_word = '0;
        m_sum  = '0;
        m_err  = 0;
    endfunction

    function automatic void model_edge(input bit iv, input logic [DATABIT-1:0] d, input bit ordy);
        m_err = 0;
        if (m_hold) begin
            if (iv) m_err = 1;
            if (ordy) m_hold = 0;
        end else if (m_q.size() == 0) begin
            if (iv) m_q.push_back(d);
        end else if (iv) begin
            m_q.push_back(d);
            if (m_q.size() == BEATS) begin
                m_word = '0;
                m_sum  = '0;
                for (int i = 0; i < int'(BEATS); i++) begin
                    m_word = m_word | (OUTBIT'(m_q[i]) << (i * DATABIT));
                    m_sum  = m_sum + m_q[i];
                end
                m_hold = 1;
                m_q.delete();
            end
        end else begin
            m_q.delete();
            m_err = 1;
        end
    endfunction

    task automatic compare_all();
        check("in_ready",  in_ready,  !m_hold && (m_q.size() == 0));
        check("out_valid", out_valid, m_hold);
        check("out_err",   out_err,   m_err);
        check("out_data",  out_data,  m_word);
`ifdef BURST_PACKER_CHKSUM_EN
        check("out_sum",   out_sum,   m_sum);
`endif
    endtask

    // One clock: drive on the falling edge, model the rising edge, compare just after.
    task automatic step(input bit iv, input logic [DATABIT-1:0] d, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, d, ordy);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse away from any rising edge.
    task automatic async_reset();
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
    endtask

    int run_len;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  '0);
        @(negedge clk);
        rst = 1'b1;

        // Normal burst with consumer ready.
        step(1, 32'h11, 1);
        step(1, 32'h22, 1);
        step(1, 32'h33, 1);
        step(1, 32'h44, 1);
        check("burst_valid", out_valid, 1'b1);
        check("burst_data", out_data, 128'h00000044_00000033_00000022_00000011);
        step(0, 32'h0, 1);
        check("burst_ready_after_hs", in_ready, 1'b1);

        // Backpressure, then an overrunning burst.
        step(1, 32'h55, 0);
        step(1, 32'h66, 0);
        step(1, 32'h77, 0);
        step(1, 32'h88, 0);
        for (int i = 0; i < 10; i++) step(0, 32'h0, 0);
        check("bp_valid_held", out_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1, DATABIT'(32'hA0 + i), 0);
            check("bp_overrun_err", out_err, 1'b1);
            check("bp_ready_low", in_ready, 1'b0);
            check("bp_data_held", out_data, 128'h00000088_00000077_00000066_00000055);
        end
        step(0, 32'h0, 1);
        check("bp_err_clear", out_err, 1'b0);

        // Short burst.
        step(1, 32'h1, 1);
        step(1, 32'h2, 1);
        step(1, 32'h3, 1);
        step(0, 32'h0, 1);
        check("short_err", out_err, 1'b1);
        check("short_no_valid", out_valid, 1'b0);
        step(0, 32'h0, 1);
        check("short_err_one_cycle", out_err, 1'b0);
        check("short_ready", in_ready, 1'b1);

        // Overrun in the handshake cycle followed by leftover beats.
        step(1, 32'hB0, 0);
        step(1, 32'hB1, 0);
        step(1, 32'hB2, 0);
        step(1, 32'hB3, 0);
        step(1, 32'hB4, 1);
        check("hs_overrun_err", out_err, 1'b1);
        step(1, 32'hB5, 1);
        step(0, 32'h0, 1);
        check("leftover_short_err", out_err, 1'b1);

        // Reset in the middle of a burst.
        step(1, 32'hC0, 1);
        step(1, 32'hC1, 1);
        async_reset();
        step(1, 32'h1, 1);
        step(1, 32'h2, 1);
        step(1, 32'h3, 1);
        step(1, 32'h4, 1);
        check("midrst_data", out_data, 128'h00000004_00000003_00000002_00000001);
        step(0, 32'h0, 1);

`ifdef BURST_PACKER_CHKSUM_EN
        step(1, 32'hFFFFFFFF, 1);
        step(1, 32'h1, 1);
        step(1, 32'h2, 1);
        step(1, 32'h3, 1);
        check("chksum", out_sum, 32'h5);
        step(0, 32'h0, 1);
`endif

        // Random traffic: runs of beats of varied length, random backpressure.
        run_len = 0;
        for (int c = 0; c < 3000; c++) begin
            bit iv;
            if (run_len == 0 && ($urandom % 4) == 0) run_len = $urandom_range(1, 6);
            iv = (run_len > 0);
            if (run_len > 0) run_len--;
            step(iv, DATABIT'($urandom), ($urandom % 3) != 0);
            if (c == 1500) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
